// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a bank of common-cathode
// seven-segment digits. A per-digit register file of {value, mode, blink} is
// decoded through the NUMBER/ALPHABET glyph set, one digit at a time.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high; clears all state
//   en         display enable; 0 blanks outputs and freezes scanning
//   wr         write strobe for the digit register file
//   wr_digit   target digit index (out-of-range indices are ignored)
//   wr_value   glyph code
//   wr_mode    0 = NUMBER, 1 = ALPHABET
//   wr_blink   1 = digit blinks
//   an         one-hot digit enable, active-high, registered
//   seg        segments {A,B,C,D,E,F,G}, seg[6] = A, registered
//   frame_tick one-cycle pulse aligned with the first cycle of digit 0
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  wr,
  input  logic [IDX_W-1:0]      wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  wr_mode,
  input  logic                  wr_blink,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [6:0] decode(input logic [3:0] v, input logic alpha);
    logic [6:0] g;
    g = 7'b0000000;
    if (!alpha) begin
      case (v)
        4'd0:    g = 7'b1111110;
        4'd1:    g = 7'b0110000;
        4'd2:    g = 7'b1101101;
        4'd3:    g = 7'b1111001;
        4'd4:    g = 7'b0110011;
        4'd5:    g = 7'b1011011;
        4'd6:    g = 7'b1011111;
        4'd7:    g = 7'b1110010;
        4'd8:    g = 7'b1111111;
        4'd9:    g = 7'b1111011;
        default: g = 7'b0000000;
      endcase
    end else begin
      case (v)
        4'd1:    g = 7'b1110111; // A
        4'd2:    g = 7'b0111101; // d
        4'd3:    g = 7'b1001111; // E
        4'd4:    g = 7'b1000111; // F
        4'd5:    g = 7'b0110111; // H
        4'd6:    g = 7'b0000110; // I
        4'd7:    g = 7'b0010101; // n
        4'd8:    g = 7'b1111110; // O
        4'd9:    g = 7'b1100111; // P
        4'd10:   g = 7'b0000101; // r
        4'd11:   g = 7'b1011011; // S
        4'd12:   g = 7'b0001111; // t
        4'd13:   g = 7'b0111110; // U
        default: g = 7'b0000000; // space, 14, 15
      endcase
    end
    return g;
  endfunction

  // Register file
  logic [3:0]            value_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mode_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic                  wr_ok;

  assign wr_ok = wr && (32'(wr_digit) < NUM_DIGITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) value_q[i] <= 4'd0;
      mode_q  <= '1;
      blink_q <= '0;
    end else if (wr_ok) begin
      value_q[wr_digit] <= wr_value;
      mode_q[wr_digit]  <= wr_mode;
      blink_q[wr_digit] <= wr_blink;
    end
  end

  // Scan state
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  // Set on the wrap edge; consumed one enabled edge later so that
  // frame_tick lines up with the registered an = one-hot(0).
  logic                  wrap_pend_q, wrap_pend_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  frame_tick_d;

  always_comb begin
    div_cnt_d     = div_cnt_q;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    wrap_pend_d   = wrap_pend_q;
    frame_tick_d  = 1'b0;
    if (en) begin
      frame_tick_d = wrap_pend_q;
      wrap_pend_d  = 1'b0;
      div_cnt_d    = div_cnt_q + 1'b1;
      if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt_d = '0;
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          idx_d       = '0;
          wrap_pend_d = 1'b1;
          if (frame_cnt_q == FRM_W'(BLINK_DIV - 1)) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    an_d  = '0;
    seg_d = 7'b0000000;
    if (en) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) an_d[i] = (idx_q == IDX_W'(i));
      if (!(blink_q[idx_q] && blink_phase_q)) seg_d = decode(value_q[idx_q], mode_q[idx_q]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      wrap_pend_q   <= 1'b0;
      an            <= '0;
      seg           <= 7'b0000000;
      frame_tick    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      wrap_pend_q   <= wrap_pend_d;
      an            <= an_d;
      seg           <= seg_d;
      frame_tick    <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with NUM_DIGITS=4,
// SCAN_DIV=4, BLINK_DIV=2. m counts enabled clock edges since the last reset;
// after enabled edge m the panel shows digit ((m-1)/4)%4.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       wr;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic       wr_mode;
  logic       wr_blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int m       = 0;

  logic [6:0] num_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                               7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                               7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  logic [6:0] alp_tab [16] = '{7'b0000000, 7'b1110111, 7'b0111101, 7'b1001111,
                               7'b1000111, 7'b0110111, 7'b0000110, 7'b0010101,
                               7'b1111110, 7'b1100111, 7'b0000101, 7'b1011011,
                               7'b0001111, 7'b0111110, 7'b0000000, 7'b0000000};

  seven_seg_scanner #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .wr        (wr),
    .wr_digit  (wr_digit),
    .wr_value  (wr_value),
    .wr_mode   (wr_mode),
    .wr_blink  (wr_blink),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (m=%0d): observed %0h expected %0h", tag, m, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en && !reset) m++;
  endtask

  task automatic chk_scan(input logic [6:0] seg_exp);
    int idx;
    idx = ((m - 1) / 4) % 4;
    chk("an", {28'd0, an}, 32'd1 << idx);
    chk("seg", {25'd0, seg}, {25'd0, seg_exp});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, (m > 1) && ((m - 1) % 16 == 0)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    wr    = 1'b0;
    #3;
    reset = 1'b0;
    m     = 0;
  endtask

  task automatic wr_entry(input int d, input int v, input logic md, input logic bl);
    wr       = 1'b1;
    wr_digit = 2'(d);
    wr_value = 4'(v);
    wr_mode  = md;
    wr_blink = bl;
    step();
    wr = 1'b0;
  endtask

  initial begin
    int idx;
    int ph;
    logic [6:0] e;

    reset = 1'b1; en = 1'b0; wr = 1'b0;
    wr_digit = 2'd0; wr_value = 4'd0; wr_mode = 1'b0; wr_blink = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_an", {28'd0, an}, 32'd0);
    chk("rst_seg", {25'd0, seg}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    step();
    reset = 1'b0;
    m = 0;

    // Disabled: outputs stay blank
    step();
    chk("dis_an", {28'd0, an}, 32'd0);
    chk("dis_seg", {25'd0, seg}, 32'd0);

    // Plain scan of spaces over 2.5 frames
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk_scan(7'b0000000);
    end

    // Write to the digit on display: visible one cycle after the write edge
    do_reset();
    en = 1'b1;
    step();
    chk("wsame_an", {28'd0, an}, 32'b0001);
    wr = 1'b1; wr_digit = 2'd0; wr_value = 4'd1; wr_mode = 1'b1; wr_blink = 1'b0;
    step();
    wr = 1'b0;
    chk("wsame_old", {25'd0, seg}, 32'd0);
    step();
    chk("wsame_new", {25'd0, seg}, {25'd0, 7'b1110111});

    // NUMBER decode on digit 2
    for (int c = 0; c < 16; c++) begin
      do_reset();
      wr_entry(2, c, 1'b0, 1'b0);
      en = 1'b1;
      repeat (9) step();
      chk("num_an", {28'd0, an}, 32'b0100);
      chk($sformatf("num_seg%0d", c), {25'd0, seg}, {25'd0, num_tab[c]});
    end

    // ALPHABET decode on digit 0
    for (int c = 0; c < 16; c++) begin
      do_reset();
      wr_entry(0, c, 1'b1, 1'b0);
      en = 1'b1;
      step();
      chk("alp_an", {28'd0, an}, 32'b0001);
      chk($sformatf("alp_seg%0d", c), {25'd0, seg}, {25'd0, alp_tab[c]});
    end

    // Blink: digit 1 blinks, digit 3 steady; blank in frames 2-3 of each 4
    do_reset();
    wr_entry(1, 8, 1'b0, 1'b1);
    wr_entry(3, 8, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 132; i++) begin
      step();
      idx = ((m - 1) / 4) % 4;
      ph  = ((m - 1) / 32) % 2;
      if (idx == 3)      e = 7'b1111111;
      else if (idx == 1) e = (ph == 1) ? 7'b0000000 : 7'b1111111;
      else               e = 7'b0000000;
      chk_scan(e);
    end

    // Enable dropped mid-digit; a write while disabled still lands
    do_reset();
    wr_entry(1, 8, 1'b0, 1'b0);
    en = 1'b1;
    repeat (6) step();
    chk_scan(7'b1111111);
    en = 1'b0;
    wr = 1'b1; wr_digit = 2'd2; wr_value = 4'd3; wr_mode = 1'b0; wr_blink = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      wr = 1'b0;
      chk("hold_an", {28'd0, an}, 32'd0);
      chk("hold_seg", {25'd0, seg}, 32'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      idx = ((m - 1) / 4) % 4;
      if (idx == 1)      e = 7'b1111111;
      else if (idx == 2) e = 7'b1111001;
      else               e = 7'b0000000;
      chk_scan(e);
    end

    // Asynchronous reset mid-frame, while frame_tick is high
    do_reset();
    wr_entry(0, 8, 1'b0, 1'b0);
    wr_entry(2, 1, 1'b0, 1'b0);
    en = 1'b1;
    repeat (17) step();
    chk_scan(7'b1111111);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_an", {28'd0, an}, 32'd0);
    chk("arst_seg", {25'd0, seg}, 32'd0);
    chk("arst_tick", {31'd0, frame_tick}, 32'd0);
    #2;
    reset = 1'b0;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_scan(7'b0000000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
